// File: rtl/qspi_arb_pkg.sv
// Shared encodings for the QSPI arbiter: FSM states, port owner and access size.
package qspi_arb_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  typedef enum logic {OWN_FETCH = 1'b0, OWN_DATA = 1'b1} owner_t;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  // Word wins over halfword when both flags are set; neither flag means byte.
  function automatic size_t decode_size(input logic w, input logic hw);
    size_t s;
    if (w)       s = SZ_WORD;
    else if (hw) s = SZ_HALF;
    else         s = SZ_BYTE;
    return s;
  endfunction

endpackage

// File: rtl/qspi_arb_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the QSPI controller.
interface qspi_arb_if;

  logic        if_req;
  logic [31:0] if_adr;
  logic        if_ack;
  logic [31:0] if_rdata;

  logic        dm_rreq;
  logic        dm_wreq;
  logic        dm_w;
  logic        dm_hw;
  logic [31:0] dm_adr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  logic        q_read_req;
  logic        q_write_req;
  logic        q_w;
  logic        q_hw;
  logic [31:0] q_adr;
  logic [31:0] q_wdata;
  logic        q_read_valid;
  logic        q_write_finish;
  logic [31:0] q_read_data;

  logic        busy;

  modport slave (
    input  if_req, if_adr, dm_rreq, dm_wreq, dm_w, dm_hw, dm_adr, dm_wdata,
           q_read_valid, q_write_finish, q_read_data,
    output if_ack, if_rdata, dm_ack, dm_rdata,
           q_read_req, q_write_req, q_w, q_hw, q_adr, q_wdata, busy
  );

  modport master (
    output if_req, if_adr, dm_rreq, dm_wreq, dm_w, dm_hw, dm_adr, dm_wdata,
           q_read_valid, q_write_finish, q_read_data,
    input  if_ack, if_rdata, dm_ack, dm_rdata,
           q_read_req, q_write_req, q_w, q_hw, q_adr, q_wdata, busy
  );

endinterface

// File: rtl/qspi_rr_pick.sv
// Two-way round-robin pick between fetch and data; on a tie the port that
// did not win last time gets the grant.
module qspi_rr_pick
  import qspi_arb_pkg::*;
(
  input  logic   req_fetch,
  input  logic   req_data,
  input  owner_t last,
  output owner_t grant
);

  always_comb begin
    grant = OWN_DATA;
    if (req_fetch && req_data) begin
      grant = (last == OWN_DATA) ? OWN_FETCH : OWN_DATA;
    end else if (req_fetch) begin
      grant = OWN_FETCH;
    end
  end

endmodule

// File: rtl/qspi_arb.sv
// Arbitrates the fetch and data ports onto a single QSPI controller, one
// transaction at a time, with no request queueing.
module qspi_arb
  import qspi_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  qspi_arb_if.slave  bus
);

  state_t      state;
  owner_t      owner;
  owner_t      last;
  owner_t      grant;
  size_t       size;
  logic        is_write;
  logic [31:0] adr_q;
  logic [31:0] wdata_q;
  logic [31:0] if_rdata_q;
  logic [31:0] dm_rdata_q;
  logic        if_ack_q;
  logic        dm_ack_q;
  logic        rd_req_q;
  logic        wr_req_q;
  logic        dm_req;

  assign dm_req = bus.dm_rreq | bus.dm_wreq;

  qspi_rr_pick u_pick (
    .req_fetch (bus.if_req),
    .req_data  (dm_req),
    .last      (last),
    .grant     (grant)
  );

  // Request pulses are launched on the IDLE->ISSUE edge so they line up with
  // the ISSUE cycle; the owner's rdata register doubles as the capture register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      owner      <= OWN_FETCH;
      last       <= OWN_DATA;
      size       <= SZ_BYTE;
      is_write   <= 1'b0;
      adr_q      <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      rd_req_q   <= 1'b0;
      wr_req_q   <= 1'b0;
    end else begin
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.if_req || dm_req) begin
            owner <= grant;
            last  <= grant;
            state <= S_ISSUE;
            if (grant == OWN_FETCH) begin
              adr_q    <= bus.if_adr;
              size     <= SZ_WORD;
              wdata_q  <= '0;
              is_write <= 1'b0;
              rd_req_q <= 1'b1;
            end else begin
              adr_q    <= bus.dm_adr;
              size     <= decode_size(bus.dm_w, bus.dm_hw);
              wdata_q  <= bus.dm_wdata;
              is_write <= bus.dm_wreq;
              rd_req_q <= ~bus.dm_wreq;
              wr_req_q <= bus.dm_wreq;
            end
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (is_write) begin
            if (bus.q_write_finish) begin
              state    <= S_DONE;
              dm_ack_q <= 1'b1;
            end
          end else if (bus.q_read_valid) begin
            state <= S_DONE;
            if (owner == OWN_FETCH) begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= bus.q_read_data;
            end else begin
              dm_ack_q   <= 1'b1;
              dm_rdata_q <= bus.q_read_data;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.if_ack      = if_ack_q;
  assign bus.if_rdata    = if_rdata_q;
  assign bus.dm_ack      = dm_ack_q;
  assign bus.dm_rdata    = dm_rdata_q;
  assign bus.q_read_req  = rd_req_q;
  assign bus.q_write_req = wr_req_q;
  assign bus.q_w         = (size == SZ_WORD);
  assign bus.q_hw        = (size == SZ_HALF);
  assign bus.q_adr       = adr_q;
  assign bus.q_wdata     = wdata_q;
  assign bus.busy        = (state != S_IDLE);

endmodule

// File: tb/tb_qspi_arb.sv
// Scoreboard bench for qspi_arb: expected QSPI transactions are queued as
// requests are raised and checked against the issue and ack the DUT produces.
module tb_qspi_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  qspi_arb_if bus();

  qspi_arb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        fetch;
    logic        wr;
    logic [31:0] adr;
    logic        w;
    logic        hw;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  txn_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_dm_rdata = '0;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic f, input logic r, input logic w);
    bus.if_req  = f;
    bus.dm_rreq = r;
    bus.dm_wreq = w;
  endtask

  task automatic pushTxn(input logic fetch, input logic wr, input logic [31:0] adr,
                         input logic w, input logic hw, input logic [31:0] wdata,
                         input logic [31:0] rdata);
    txn_t t;
    t.fetch = fetch; t.wr = wr; t.adr = adr; t.w = w; t.hw = hw;
    t.wdata = wdata; t.rdata = rdata;
    exp_q.push_back(t);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_q_adr"}, bus.q_adr, 32'h0);
    checkOutput({tag, "_q_wdata"}, bus.q_wdata, 32'h0);
    checkOutput({tag, "_if_rdata"}, bus.if_rdata, 32'h0);
    checkOutput({tag, "_dm_rdata"}, bus.dm_rdata, 32'h0);
    checkOutput({tag, "_ctl"},
                {bus.if_ack, bus.dm_ack, bus.q_read_req, bus.q_write_req,
                 bus.q_w, bus.q_hw, bus.busy}, 32'h0);
  endtask

  // Waits for an issue pulse, pops the scoreboard and checks the issued command.
  task automatic waitIssue(output txn_t e, output bit ok);
    bit seen = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = bus.q_read_req | bus.q_write_req;
    end
    if (!seen) begin
      checkOutput("issue_timeout", 32'h0, 32'h1);
      return;
    end
    if (exp_q.size() == 0) begin
      checkOutput("unexpected_issue", 32'h1, 32'h0);
      return;
    end
    e = exp_q.pop_front();
    ok = 1'b1;
    checkOutput("q_read_req", bus.q_read_req, !e.wr);
    checkOutput("q_write_req", bus.q_write_req, e.wr);
    checkOutput("q_adr", bus.q_adr, e.adr);
    checkOutput("q_w", bus.q_w, e.w);
    checkOutput("q_hw", bus.q_hw, e.hw);
    if (e.wr) checkOutput("q_wdata", bus.q_wdata, e.wdata);
    checkOutput("busy_issue", bus.busy, 1'b1);
  endtask

  task automatic serveOne(input int delay, input bit stray,
                          input bit drop_if, input bit drop_r, input bit drop_w);
    txn_t e;
    bit   ok;
    bit   early = 1'b0;
    waitIssue(e, ok);
    if (!ok) return;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      early |= bus.if_ack | bus.dm_ack;
      bus.q_write_finish = (stray && i == delay / 2);
    end
    checkOutput("early_ack", early, 1'b0);
    bus.q_write_finish = e.wr;
    bus.q_read_valid   = !e.wr;
    bus.q_read_data    = e.rdata;
    @(negedge clk);
    bus.q_read_valid   = 1'b0;
    bus.q_write_finish = 1'b0;
    bus.q_read_data    = 32'h0BAD_0BAD;
    if (!e.wr) begin
      if (e.fetch) exp_if_rdata = e.rdata;
      else         exp_dm_rdata = e.rdata;
    end
    checkOutput("if_ack", bus.if_ack, e.fetch);
    checkOutput("dm_ack", bus.dm_ack, !e.fetch);
    checkOutput("if_rdata", bus.if_rdata, exp_if_rdata);
    checkOutput("dm_rdata", bus.dm_rdata, exp_dm_rdata);
    if (drop_if) bus.if_req  = 1'b0;
    if (drop_r)  bus.dm_rreq = 1'b0;
    if (drop_w)  bus.dm_wreq = 1'b0;
    @(negedge clk);
    checkOutput("ack_one_cycle", {bus.if_ack, bus.dm_ack}, 2'b00);
    checkOutput("busy_after_done", bus.busy, 1'b0);
    checkOutput("if_rdata_hold", bus.if_rdata, exp_if_rdata);
    checkOutput("dm_rdata_hold", bus.dm_rdata, exp_dm_rdata);
  endtask

  task automatic expectQuiet(input string tag, input int n);
    bit seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      seen |= bus.q_read_req | bus.q_write_req | bus.if_ack | bus.dm_ack | bus.busy;
    end
    checkOutput(tag, seen, 1'b0);
  endtask

  initial begin
    txn_t e;
    bit   ok;
    applyStimulus(1'b0, 1'b0, 1'b0);
    bus.if_adr = '0;   bus.dm_adr = '0;   bus.dm_wdata = '0;
    bus.dm_w = 1'b0;   bus.dm_hw = 1'b0;
    bus.q_read_valid = 1'b0; bus.q_write_finish = 1'b0; bus.q_read_data = '0;
    repeat (2) @(negedge clk);
    checkReset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] lone fetch");
    bus.if_adr = 32'h100;
    pushTxn(1'b1, 1'b0, 32'h100, 1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 1'b0, 1'b0);
    serveOne(10, 1'b0, 1'b1, 1'b0, 1'b0);
    expectQuiet("fetch_no_dup", 4);

    $display("[TB] tie from reset");
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_if_rdata = '0; exp_dm_rdata = '0;
    bus.dm_adr = 32'h200; bus.dm_w = 1'b1; bus.dm_hw = 1'b0;
    pushTxn(1'b1, 1'b0, 32'h100, 1'b1, 1'b0, 32'h0, 32'h1111_0001);
    pushTxn(1'b0, 1'b0, 32'h200, 1'b1, 1'b0, 32'h0, 32'h2222_0002);
    pushTxn(1'b1, 1'b0, 32'h100, 1'b1, 1'b0, 32'h0, 32'h3333_0003);
    pushTxn(1'b0, 1'b0, 32'h200, 1'b1, 1'b0, 32'h0, 32'h4444_0004);
    applyStimulus(1'b1, 1'b1, 1'b0);
    serveOne(3, 1'b0, 1'b0, 1'b0, 1'b0);
    serveOne(2, 1'b0, 1'b0, 1'b0, 1'b0);
    serveOne(4, 1'b0, 1'b0, 1'b0, 1'b0);
    serveOne(1, 1'b0, 1'b1, 1'b1, 1'b0);
    expectQuiet("tie_no_extra", 4);

    $display("[TB] write priority");
    bus.dm_adr = 32'h300; bus.dm_w = 1'b0; bus.dm_hw = 1'b1; bus.dm_wdata = 32'h1234;
    pushTxn(1'b0, 1'b1, 32'h300, 1'b0, 1'b1, 32'h1234, 32'h0);
    pushTxn(1'b0, 1'b0, 32'h300, 1'b0, 1'b1, 32'h0, 32'hCAFE_0055);
    applyStimulus(1'b0, 1'b1, 1'b1);
    serveOne(4, 1'b0, 1'b0, 1'b0, 1'b1);
    serveOne(3, 1'b0, 1'b0, 1'b1, 1'b0);
    expectQuiet("read_no_dup", 4);

    $display("[TB] stray write_finish during read");
    bus.if_adr = 32'h400;
    pushTxn(1'b1, 1'b0, 32'h400, 1'b1, 1'b0, 32'h0, 32'h5555_AAAA);
    applyStimulus(1'b1, 1'b0, 1'b0);
    serveOne(6, 1'b1, 1'b1, 1'b0, 1'b0);
    expectQuiet("stray_quiet", 3);

    $display("[TB] reset in WAIT");
    bus.if_adr = 32'h500;
    pushTxn(1'b1, 1'b0, 32'h500, 1'b1, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitIssue(e, ok);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkReset("midwait");
    exp_if_rdata = '0; exp_dm_rdata = '0;
    rst_n = 1'b1;
    bus.q_read_valid = 1'b1; bus.q_read_data = 32'hFEED_F00D;
    @(negedge clk);
    bus.q_read_valid = 1'b0; bus.q_write_finish = 1'b1;
    @(negedge clk);
    bus.q_write_finish = 1'b0;
    checkOutput("late_rdata", bus.if_rdata, 32'h0);
    expectQuiet("late_pulse_quiet", 3);
    bus.dm_adr = 32'h601; bus.dm_w = 1'b0; bus.dm_hw = 1'b0;
    pushTxn(1'b0, 1'b0, 32'h601, 1'b0, 1'b0, 32'h0, 32'h0000_0077);
    applyStimulus(1'b0, 1'b1, 1'b0);
    serveOne(2, 1'b0, 1'b0, 1'b1, 1'b0);
    expectQuiet("post_reset_quiet", 3);

    checkOutput("scoreboard_empty", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/qspi_arb.md
QSPI_ARB -- requirements
Module: qspi_arb

Interface
REQ-001 clk  input  1  system clock; all state in qspi_arb SHALL update on its rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 if_req  input  1  fetch read request; level, held until if_ack.
REQ-004 if_adr  input  32  fetch byte address.
REQ-005 if_ack  output  1  one-cycle pulse; if_rdata valid in the same cycle.
REQ-006 if_rdata  output  32  fetch read data.
REQ-007 dm_rreq  input  1  data-port read request; level, held until dm_ack.
REQ-008 dm_wreq  input  1  data-port write request; level, held until dm_ack.
REQ-009 dm_w  input  1  word access.
REQ-010 dm_hw  input  1  halfword access (dm_w=0, dm_hw=0 means byte).
REQ-011 dm_adr  input  32  data byte address.
REQ-012 dm_wdata  input  32  write data.
REQ-013 dm_ack  output  1  one-cycle pulse; dm_rdata valid in the same cycle for reads.
REQ-014 dm_rdata  output  32  data-port read data.
REQ-015 q_read_req, q_write_req  output  1 each  one-cycle request pulses to the QSPI interface.
REQ-016 q_w, q_hw  output  1 each  access size to the QSPI interface.
REQ-017 q_adr  output  32  address, driven on both the read and write address ports.
REQ-018 q_wdata  output  32  write data.
REQ-019 q_read_valid, q_write_finish  input  1 each  completion pulses from the QSPI interface.
REQ-020 q_read_data  input  32  read data, valid with q_read_valid.
REQ-021 busy  output  1  high in every state except IDLE.

Function
REQ-022 States: IDLE, ISSUE, WAIT, DONE; the owner register is {FETCH, DATA}; the last register holds the owner of the most recent grant.
REQ-023 In IDLE, when any request is high, the block SHALL latch the owner, address, size and wdata and enter ISSUE on the next clock.
REQ-024 Round-robin: when if_req and a data request are high together, the grant SHALL go to the requester not equal to last; last resets to DATA, so fetch wins the first tie.
REQ-025 Within the data port, a write SHALL take priority when dm_rreq and dm_wreq are both high.
REQ-026 A fetch SHALL always issue q_w=1, q_hw=0 as a read.
REQ-027 ISSUE SHALL last exactly one cycle, assert exactly one of q_read_req/q_write_req for that cycle, then enter WAIT.
REQ-028 q_adr, q_w, q_hw and q_wdata SHALL be registered and stable from ISSUE through DONE.
REQ-029 WAIT SHALL exit to DONE on q_read_valid for reads and on q_write_finish for writes; the other pulse SHALL be ignored.
REQ-030 On that pulse q_read_data SHALL be captured into a 32-bit register.
REQ-031 In DONE, the owner's ack SHALL be high for exactly one cycle, with its rdata equal to the captured value.
REQ-032 Writes SHALL leave rdata unchanged.
REQ-033 DONE SHALL always go to IDLE, giving the requester one cycle to drop its request before arbitration resumes.
REQ-034 Minimum request-to-ack latency is ISSUE+1 cycles plus the QSPI transaction time; a new q_*_req SHALL not issue sooner than 2 cycles after the previous ack.
REQ-035 Requests that drop while not granted SHALL be forgotten; the block keeps no queue.
REQ-036 if_rdata/dm_rdata SHALL hold their last value between acks.

Reset
REQ-037 On rst_n low: state=IDLE, last=DATA.
REQ-038 On rst_n low, every output SHALL be 0, including q_adr, q_wdata and both rdata registers.
REQ-039 A reset during WAIT SHALL abandon the transaction with no ack.
REQ-040 After reset, late q_read_valid/q_write_finish pulses SHALL be ignored in IDLE.

Structure
REQ-041 A shared package SHALL hold the state encoding, the owner encoding and the access-size encoding (byte/half/word).
REQ-042 One sub-module, qspi_rr_pick, SHALL hold the combinational two-way round-robin selection: inputs two requests plus last, output grant.

Verification
REQ-043 Lone fetch: if_req, if_adr=0x100; q_read_valid with data 0xDEADBEEF 10 cycles after ISSUE -> one q_read_req pulse with q_w=1, if_ack one cycle after valid, if_rdata=0xDEADBEEF.
REQ-044 Tie: if_req and dm_rreq high together from reset, both held -> grant order fetch, data, fetch, data; exactly one q_read_req per grant.
REQ-045 Data write: dm_wreq and dm_rreq both high, dm_hw=1, dm_wdata=0x1234 -> q_write_req with q_hw=1, q_wdata=0x1234; dm_ack on the cycle after q_write_finish; the read is granted afterwards.
REQ-046 Stray pulse: a q_write_finish during a read WAIT -> no ack; the read completes normally on q_read_valid.
REQ-047 Reset mid-WAIT: rst_n pulsed low in WAIT, then q_read_valid arrives -> no ack; busy=0; next request served normally.
REQ-048 Back-to-back: held dm_rreq released on the cycle after ack -> no duplicate q_read_req.
